systolic_mm_ctrl: RTL and testbench
===================================

# systolic_mm_ctrl

Sequencing controller for the `MATRIX_SIZE`×`MATRIX_SIZE` systolic MAC array used in the ECG classifier datapath. It buffers operand matrices A and B, clears the array, and feeds A rows and B columns with the diagonal skew the array needs. It waits for the array to drain, captures the full result matrix and signals completion with a start/done handshake. It sits between the layer sequencer (operand loads, start) and the array instance.

## Interface
- `MATRIX_SIZE`, 16, array dimension N.
- `DATA_SIZE`, 8, signed element width.
- `DRAIN_CYCLES`, `MATRIX_SIZE`, cycles spent in DRAIN after the last operand is issued.
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `wr_en`  in  1  operand row write strobe.
- `wr_sel`  in  1  0 = write A, 1 = write B.
- `wr_row`  in  $clog2(N)  row index.
- `wr_data`  in  N×DATA_SIZE signed (unpacked [N-1:0])  row contents; element k is column k.
- `wr_err`  out  1  one-cycle pulse when a write is dropped because the block is busy.
- `start`  in  1  begin multiply; sampled only in IDLE.
- `busy`  out  1  high in CLEAR, FEED, DRAIN, DONE.
- `done`  out  1  one-cycle pulse when results are captured.
- `result_valid`  out  1  result registers hold a completed product.
- `result`  out  N*N×DATA_SIZE signed  captured C; element i*N+j = C[i][j].
- `arr_rst`  out  1  synchronous-registered clear to the array's reset.
- `arr_a`  out  N×DATA_SIZE signed  drives array `in_a`.
- `arr_b`  out  N×DATA_SIZE signed  drives array `in_b`.
- `arr_out`  in  N*N×DATA_SIZE signed  array `out_matrix`.

## Operation
- Operand buffers: two N×N register files. A write while IDLE updates the addressed row. A write while busy is dropped and `wr_err` pulses. Buffers are not cleared by reset (contents undefined) and are retained across multiplies.
- FSM states: IDLE → (start) CLEAR → FEED → DRAIN → DONE → IDLE.
- CLEAR: 1 cycle, `arr_rst`=1. This zeroes the array accumulators and pipeline registers.
- FEED: 2N-1 cycles, step counter t = 0..2N-2.
  - `arr_a[i]` = A[i][t-i] when 0 ≤ t-i < N, else 0.
  - `arr_b[j]` = B[t-j][j] when 0 ≤ t-j < N, else 0.
- DRAIN: `DRAIN_CYCLES` cycles, `arr_a`/`arr_b` = 0.
- DONE: 1 cycle.
  - `result` ← `arr_out`.
  - `done`=1.
  - `result_valid` set.
- `result_valid` clears on the cycle a new `start` is accepted; `result` keeps its old value until the next DONE.
- `arr_a`/`arr_b` are 0 in every state except FEED.
- Arithmetic: the controller performs none. Results are the array's DATA_SIZE-bit wrapped values, captured unmodified.
- `start` outside IDLE is ignored (no queueing). `start` and `wr_en` in the same IDLE cycle: the write is applied and the multiply uses the updated row.

## Timing
- Reset values:
  - FSM = IDLE.
  - `busy`=0, `done`=0, `result_valid`=0, `wr_err`=0.
  - `arr_rst`=1 while reset is asserted, then 0.
  - `arr_a`/`arr_b`=0, `result`=0.
- All outputs are registered. `arr_a`/`arr_b` for step t are presented in FEED cycle t.
- Latency: `start` sampled at edge 0 → CLEAR in cycle 1, FEED in cycles 2..2N, DRAIN in cycles 2N+1..2N+DRAIN_CYCLES, `done` in cycle 2N+DRAIN_CYCLES+1 (3N+1 with defaults; 49 for N=16).
- `busy` rises the cycle after `start` and falls the cycle after `done`. The next `start` is accepted in the cycle after `done`.
- Reset mid-operation: immediate return to IDLE, `result_valid`=0, no `done`, array cleared via `arr_rst`.

## Test plan
- N=4, A=identity, B[i][j]=4i+j+1; write all rows, start → `done` exactly 13 cycles after start, `result`=B, `result_valid`=1.
- N=4, A[i][j]=1, B[i][j]=2 → every C element = 8. Then a second start without reloading → identical result (buffers retained, array cleared by CLEAR).
- N=4, A[i][j]=127, B[i][j]=127 → each element = (4·16129) mod 256 = 4 (signed wrap), captured unchanged.
- `wr_en` asserted during FEED → `wr_err` pulses one cycle, and the product equals the pre-write operands. `start` pulses during DRAIN → ignored, only one `done`.
- Check `arr_a`/`arr_b` cycle by cycle in FEED: lane i is zero for t<i and for t>i+N-1, and carries A[i][t-i] (or B[t-i][i]) otherwise. Both buses are 0 in CLEAR and DRAIN.
- Assert `reset` in FEED step 3 → `busy`=0, `result_valid`=0, and no `done` within 20 cycles. A subsequent start completes normally with the correct result.

Source files
------------

// File: rtl/systolic_mm_ctrl.sv
// rtl/systolic_mm_ctrl.sv - operand buffering, skewed feed and result capture for an NxN systolic MAC array
module systolic_mm_ctrl #(
    parameter int MATRIX_SIZE  = 16,
    parameter int DATA_SIZE    = 8,
    parameter int DRAIN_CYCLES = MATRIX_SIZE
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic                        wr_sel,
    input  logic [$clog2(MATRIX_SIZE)-1:0] wr_row,
    input  logic signed [DATA_SIZE-1:0] wr_data [MATRIX_SIZE-1:0],
    output logic                        wr_err,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        result_valid,
    output logic signed [DATA_SIZE-1:0] result [MATRIX_SIZE*MATRIX_SIZE-1:0],
    output logic                        arr_rst,
    output logic signed [DATA_SIZE-1:0] arr_a [MATRIX_SIZE-1:0],
    output logic signed [DATA_SIZE-1:0] arr_b [MATRIX_SIZE-1:0],
    input  logic signed [DATA_SIZE-1:0] arr_out [MATRIX_SIZE*MATRIX_SIZE-1:0]
);

    localparam int N         = MATRIX_SIZE;
    localparam int IDX_W     = $clog2(N);
    localparam int FEED_LAST = 2 * N - 2;
    localparam int CNT_MAX   = (2 * N > DRAIN_CYCLES) ? 2 * N : DRAIN_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic signed [DATA_SIZE-1:0] a_mem [N-1:0][N-1:0];
    logic signed [DATA_SIZE-1:0] b_mem [N-1:0][N-1:0];
    logic signed [DATA_SIZE-1:0] arr_a_q [N-1:0];
    logic signed [DATA_SIZE-1:0] arr_a_d [N-1:0];
    logic signed [DATA_SIZE-1:0] arr_b_q [N-1:0];
    logic signed [DATA_SIZE-1:0] arr_b_d [N-1:0];
    logic signed [DATA_SIZE-1:0] result_q [N*N-1:0];
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        result_valid_q, result_valid_d;
    logic                        wr_err_q, wr_err_d;
    logic                        arr_rst_q, arr_rst_d;
    logic                        wr_accept;

    assign wr_accept = wr_en && (state_q == S_IDLE);

    // cnt is the FEED step t, reused as the DRAIN cycle counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                state_d = S_FEED;
                cnt_d   = '0;
            end
            S_FEED: begin
                if (cnt_q == CNT_W'(FEED_LAST)) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the next state
    always_comb begin
        busy_d         = (state_d != S_IDLE);
        done_d         = (state_d == S_DONE);
        arr_rst_d      = (state_d == S_CLEAR);
        wr_err_d       = wr_en && (state_q != S_IDLE);
        result_valid_d = result_valid_q;
        if (state_q == S_IDLE && start) begin
            result_valid_d = 1'b0;
        end
        if (state_d == S_DONE) begin
            result_valid_d = 1'b1;
        end
    end

    // Diagonal skew: lane i carries element t-i of its row/column
    always_comb begin
        int k;
        k = 0;
        for (int i = 0; i < N; i++) begin
            arr_a_d[i] = '0;
            arr_b_d[i] = '0;
            if (state_d == S_FEED) begin
                k = int'(cnt_d) - i;
                if (k >= 0 && k < N) begin
                    arr_a_d[i] = a_mem[i][IDX_W'(k)];
                    arr_b_d[i] = b_mem[IDX_W'(k)][i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            result_valid_q <= 1'b0;
            wr_err_q       <= 1'b0;
            arr_rst_q      <= 1'b1;
            for (int i = 0; i < N; i++) begin
                arr_a_q[i] <= '0;
                arr_b_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            result_valid_q <= result_valid_d;
            wr_err_q       <= wr_err_d;
            arr_rst_q      <= arr_rst_d;
            for (int i = 0; i < N; i++) begin
                arr_a_q[i] <= arr_a_d[i];
                arr_b_q[i] <= arr_b_d[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < N * N; e++) begin
                result_q[e] <= '0;
            end
        end else if (state_d == S_DONE) begin
            for (int e = 0; e < N * N; e++) begin
                result_q[e] <= arr_out[e];
            end
        end
    end

    // Operand buffers keep their contents across reset and across multiplies
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            for (int k = 0; k < N; k++) begin
                if (wr_sel) begin
                    b_mem[wr_row][k] <= wr_data[k];
                end else begin
                    a_mem[wr_row][k] <= wr_data[k];
                end
            end
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign result_valid = result_valid_q;
    assign wr_err       = wr_err_q;
    assign arr_rst      = arr_rst_q;
    assign arr_a        = arr_a_q;
    assign arr_b        = arr_b_q;
    assign result       = result_q;

endmodule

// File: tb/tb_systolic_mm_ctrl.sv
// tb/tb_systolic_mm_ctrl.sv - directed bench for systolic_mm_ctrl with N=4 and a behavioural output-stationary array
module tb_systolic_mm_ctrl;

    localparam int N = 4;

    logic              clk;
    logic              reset;
    logic              wr_en;
    logic              wr_sel;
    logic [1:0]        wr_row;
    logic signed [7:0] wr_data [N-1:0];
    logic              wr_err;
    logic              start;
    logic              busy;
    logic              done;
    logic              result_valid;
    logic signed [7:0] result [N*N-1:0];
    logic              arr_rst;
    logic signed [7:0] arr_a [N-1:0];
    logic signed [7:0] arr_b [N-1:0];
    logic signed [7:0] arr_out [N*N-1:0];

    int nchk  = 0;
    int nfail = 0;
    int ma [N][N];
    int mb [N][N];

    systolic_mm_ctrl #(
        .MATRIX_SIZE(N),
        .DATA_SIZE  (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_row      (wr_row),
        .wr_data     (wr_data),
        .wr_err      (wr_err),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .result_valid(result_valid),
        .result      (result),
        .arr_rst     (arr_rst),
        .arr_a       (arr_a),
        .arr_b       (arr_b),
        .arr_out     (arr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output-stationary array: A flows right, B flows down, each PE accumulates
    logic signed [7:0] pa  [N][N];
    logic signed [7:0] pb  [N][N];
    logic signed [7:0] acc [N][N];
    logic signed [7:0] ain [N][N];
    logic signed [7:0] bin [N][N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            ain[i][0] = arr_a[i];
            bin[0][i] = arr_b[i];
            for (int j = 1; j < N; j++) begin
                ain[i][j] = pa[i][j-1];
                bin[j][i] = pb[j-1][i];
            end
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                arr_out[i*N+j] = acc[i][j];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (arr_rst) begin
                    pa[i][j]  <= '0;
                    pb[i][j]  <= '0;
                    acc[i][j] <= '0;
                end else begin
                    pa[i][j]  <= ain[i][j];
                    pb[i][j]  <= bin[i][j];
                    acc[i][j] <= acc[i][j] + ain[i][j] * bin[i][j];
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic write_row(input bit sel, input int r);
        wr_en  = 1'b1;
        wr_sel = sel;
        wr_row = 2'(r);
        for (int k = 0; k < N; k++) begin
            wr_data[k] = sel ? 8'(mb[r][k]) : 8'(ma[r][k]);
        end
        tick;
        wr_en = 1'b0;
    endtask

    task automatic write_all;
        for (int r = 0; r < N; r++) write_row(1'b0, r);
        for (int r = 0; r < N; r++) write_row(1'b1, r);
    endtask

    // Lanes in cycle c after start: CLEAR at 1, FEED t=c-2 for c=2..8, DRAIN 9..12
    task automatic lane_check(input int c);
        int t, ea, eb;
        t = c - 2;
        for (int i = 0; i < N; i++) begin
            ea = 0;
            eb = 0;
            if (c >= 2 && c <= 2 * N && t >= i && t - i < N) begin
                ea = ma[i][t-i];
                eb = mb[t-i][i];
            end
            chk($sformatf("arr_a[%0d]@c%0d", i, c), arr_a[i], ea);
            chk($sformatf("arr_b[%0d]@c%0d", i, c), arr_b[i], eb);
        end
    endtask

    task automatic do_mm(input int wr_at, input int st_at);
        int c;
        start = 1'b1;
        tick;
        start = 1'b0;
        wr_en = 1'b0;
        c = 1;
        chk("clear_arr_rst", arr_rst, 1);
        chk("clear_busy", busy, 1);
        chk("rv_cleared_on_start", result_valid, 0);
        while (done !== 1'b1 && c < 60) begin
            lane_check(c);
            if (c == wr_at) begin
                wr_en  = 1'b1;
                wr_sel = 1'b0;
                wr_row = 2'd0;
                for (int k = 0; k < N; k++) wr_data[k] = 8'sd5;
            end
            if (c == wr_at + 1) begin
                wr_en = 1'b0;
                chk("wr_err_pulse", wr_err, 1);
            end
            if (c == wr_at + 2) chk("wr_err_clear", wr_err, 0);
            start = (c == st_at);
            tick;
            c++;
        end
        start = 1'b0;
        wr_en = 1'b0;
        chk("done_cycle", c, 13);
        chk("rv_at_done", result_valid, 1);
        chk("busy_at_done", busy, 1);
        tick;
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
    endtask

    task automatic chk_result_const(input int v);
        for (int e = 0; e < N * N; e++) chk($sformatf("result[%0d]", e), result[e], v);
    endtask

    task automatic chk_result_b;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                chk($sformatf("result[%0d]", i*N+j), result[i*N+j], 4*i + j + 1);
    endtask

    task automatic load_identity_b;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = (i == j) ? 1 : 0;
                mb[i][j] = 4*i + j + 1;
            end
    endtask

    task automatic load_const(input int va, input int vb);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = va;
                mb[i][j] = vb;
            end
    endtask

    initial begin
        int dcnt;
        reset  = 1'b1;
        wr_en  = 1'b0;
        wr_sel = 1'b0;
        wr_row = '0;
        start  = 1'b0;
        for (int k = 0; k < N; k++) wr_data[k] = '0;
        tick;
        tick;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_wr_err", wr_err, 0);
        chk("rst_arr_rst", arr_rst, 1);
        chk("rst_arr_a0", arr_a[0], 0);
        chk("rst_arr_b3", arr_b[3], 0);
        chk("rst_result0", result[0], 0);
        reset = 1'b0;
        tick;
        chk("arr_rst_released", arr_rst, 0);

        // Identity times B gives B
        load_identity_b();
        write_all();
        do_mm(-10, -10);
        chk_result_b();

        // All-ones times all-twos, then rerun from retained buffers
        load_const(1, 2);
        write_all();
        do_mm(-10, -10);
        chk_result_const(8);
        do_mm(-10, -10);
        chk_result_const(8);
        chk("rv_held_idle", result_valid, 1);

        // 127*127 wraps; last A row is written in the same cycle as start
        load_const(127, 127);
        for (int r = 0; r < N; r++) write_row(1'b1, r);
        for (int r = 0; r < N - 1; r++) write_row(1'b0, r);
        wr_en  = 1'b1;
        wr_sel = 1'b0;
        wr_row = 2'd3;
        for (int k = 0; k < N; k++) wr_data[k] = 8'(ma[3][k]);
        do_mm(-10, -10);
        chk_result_const(4);

        // Dropped write during FEED and ignored start during DRAIN
        load_const(1, 1);
        write_all();
        do_mm(3, 10);
        chk_result_const(4);
        dcnt = 0;
        for (int n = 0; n < 20; n++) begin
            if (done === 1'b1) dcnt++;
            tick;
        end
        chk("single_done", dcnt, 0);
        chk("idle_after_drain_start", busy, 0);

        // Reset at FEED step 3, then a clean rerun
        load_identity_b();
        write_all();
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int n = 0; n < 4; n++) tick;
        chk("pre_rst_arr_b0", arr_b[0], 13);
        reset = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_rv", result_valid, 0);
        chk("midrst_arr_rst", arr_rst, 1);
        chk("midrst_arr_b0", arr_b[0], 0);
        tick;
        tick;
        reset = 1'b0;
        dcnt = 0;
        for (int n = 0; n < 20; n++) begin
            if (done === 1'b1) dcnt++;
            tick;
        end
        chk("no_done_after_rst", dcnt, 0);
        chk("rv_after_rst", result_valid, 0);
        write_all();
        do_mm(-10, -10);
        chk_result_b();

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
